// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use/branch stall-flush control, multi-cycle unit sequencing, event counters
module hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       RD_ADDR_E,
  input  logic [4:0]       RD_ADDR_M,
  input  logic [4:0]       RD_ADDR_W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             mc_reqE,
  input  logic             mc_done,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             mc_start,
  output logic             mc_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int TW = $clog2(MC_TIMEOUT);
  typedef enum logic {RUN, MC_WAIT} state_t;
  state_t state;
  logic [TW-1:0] tmo;
  logic lw_stall, tmo_hit, run, wait_stall, lw;
  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                     input logic ww, input logic [4:0] rdw);
    return (wm && rdm != 5'd0 && rdm == rs) ? 2'b10 :
           (ww && rdw != 5'd0 && rdw == rs) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    ForwardA_E = fwd(Rs1_E, RegWriteM, RD_ADDR_M, RegWriteW, RD_ADDR_W);
    ForwardB_E = fwd(Rs2_E, RegWriteM, RD_ADDR_M, RegWriteW, RD_ADDR_W);
    lw_stall   = RegWriteE && ResultSrcE == 2'b01 && RD_ADDR_E != 5'd0 &&
                 (RD_ADDR_E == Rs1_D || RD_ADDR_E == Rs2_D);
    // reset gating keeps every stall/flush low while i_rst_n is asserted
    run        = i_rst_n && state == RUN;
    tmo_hit    = i_rst_n && state == MC_WAIT && !mc_done && tmo == TW'(MC_TIMEOUT - 1);
    wait_stall = i_rst_n && state == MC_WAIT && !mc_done && !tmo_hit;
    mc_start   = run && !PCSrcE && mc_reqE;
    lw         = run && !PCSrcE && !mc_reqE && lw_stall;
    StallE     = mc_start || wait_stall;
    StallF     = StallE || lw;
    StallD     = StallF;
    FlushD     = run && PCSrcE;
    FlushE     = FlushD || lw || tmo_hit;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= RUN;
      tmo       <= '0;
      mc_err    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= (state == RUN) ? (mc_start ? MC_WAIT : RUN) : ((mc_done || tmo_hit) ? RUN : MC_WAIT);
      tmo       <= mc_start ? '0 : (state == MC_WAIT ? tmo + TW'(1) : tmo);
      mc_err    <= mc_err | tmo_hit;
      stall_cnt <= (StallF && !(&stall_cnt)) ? stall_cnt + CNT_W'(1) : stall_cnt;
      flush_cnt <= ((FlushD || FlushE) && !(&flush_cnt)) ? flush_cnt + CNT_W'(1) : flush_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with a short timeout and narrow counters
module tb_hazard_ctrl;
  localparam int TO = 8;
  localparam int CW = 4;
  logic clk, rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic rw_e, rw_m, rw_w, pcsrc, mc_req, mc_done;
  logic [1:0] rsrc, fa, fb;
  logic sf, sd, se, fd, fe, mc_start, mc_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int compared = 0, mismatched = 0, scnt = 0, fcnt = 0;
  logic [10:0] q[$];
  hazard_ctrl #(.MC_TIMEOUT(TO), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .Rs1_D(rs1_d), .Rs2_D(rs2_d), .Rs1_E(rs1_e), .Rs2_E(rs2_e),
    .RD_ADDR_E(rd_e), .RD_ADDR_M(rd_m), .RD_ADDR_W(rd_w), .RegWriteE(rw_e), .RegWriteM(rw_m),
    .RegWriteW(rw_w), .ResultSrcE(rsrc), .PCSrcE(pcsrc), .mc_reqE(mc_req), .mc_done(mc_done),
    .ForwardA_E(fa), .ForwardB_E(fb), .StallF(sf), .StallD(sd), .StallE(se), .FlushD(fd),
    .FlushE(fe), .mc_start(mc_start), .mc_err(mc_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask
  // expected = {fa, fb, sf, sd, se, fd, fe, mc_start, mc_err}; counters follow from the expected stalls/flushes
  task automatic cyc(input string tag, input logic [10:0] e);
    logic [10:0] x;
    q.push_back(e);
    @(negedge clk);
    x = q.pop_front();
    check(tag, 16'({fa, fb, sf, sd, se, fd, fe, mc_start, mc_err}), 16'(x));
    check({tag, ".scnt"}, 16'(stall_cnt), 16'(scnt));
    check({tag, ".fcnt"}, 16'(flush_cnt), 16'(fcnt));
    if (x[6] && scnt < 2**CW - 1) scnt++;
    if ((x[3] || x[2]) && fcnt < 2**CW - 1) fcnt++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {rw_e, rw_m, rw_w, pcsrc, mc_req, mc_done} = '0;
    rsrc = 2'b00;
  endtask
  initial begin
    idle_inputs();
    rst_n = 0;
    pcsrc = 1;
    mc_req = 1;
    cyc("reset", 11'b0);
    rst_n = 1;
    idle_inputs();
    cyc("run_idle", 11'b0);
    // forwarding priority and x0 suppression
    rw_m = 1; rd_m = 5; rw_w = 1; rd_w = 5; rs1_e = 5; rs2_e = 5;
    cyc("fwd_m", {2'b10, 2'b10, 7'b0});
    rw_m = 0;
    cyc("fwd_w", {2'b01, 2'b01, 7'b0});
    rw_m = 1; rd_m = 3; rs2_e = 3;
    cyc("fwd_mix", {2'b01, 2'b10, 7'b0});
    rd_m = 0; rd_w = 0; rs1_e = 0; rs2_e = 0;
    cyc("fwd_x0", 11'b0);
    idle_inputs();
    // load-use bubble then cleared
    rw_e = 1; rsrc = 2'b01; rd_e = 7; rs2_d = 7;
    cyc("lw", {4'b0, 7'b1100100});
    rw_e = 0;
    cyc("lw_bubble", 11'b0);
    rw_e = 1; rd_e = 0; rs1_d = 0;
    cyc("lw_x0", 11'b0);
    rsrc = 2'b00; rd_e = 7;
    cyc("non_load", 11'b0);
    // branch beats load-use
    rsrc = 2'b01; pcsrc = 1;
    cyc("br_lw", {4'b0, 7'b0001100});
    idle_inputs();
    mc_done = 1;
    cyc("done_in_run", 11'b0);
    mc_done = 0;
    // multi-cycle op completing on 4th cycle after start
    mc_req = 1;
    cyc("mc_start", {4'b0, 7'b1110010});
    cyc("mc_w1", {4'b0, 7'b1110000});
    pcsrc = 1;
    cyc("mc_w2_br", {4'b0, 7'b1110000});
    pcsrc = 0;
    cyc("mc_w3", {4'b0, 7'b1110000});
    mc_done = 1;
    cyc("mc_done", 11'b0);
    mc_done = 0; mc_req = 0;
    cyc("mc_after", 11'b0);
    // two timeouts: first sets the sticky error, second drives stall_cnt into saturation
    for (int r = 0; r < 2; r++) begin
      mc_req = 1;
      cyc("to_start", {4'b0, 7'b1110010 | 7'(r)});
      mc_req = 0;
      for (int i = 0; i < TO - 1; i++) cyc("to_wait", {4'b0, 7'b1110000 | 7'(r)});
      cyc("to_abort", {4'b0, 7'b0000100 | 7'(r)});
      cyc("to_err", {4'b0, 7'b0000001});
    end
    check("sat", 16'(stall_cnt), 16'(2**CW - 1));
    // asynchronous reset in the middle of MC_WAIT
    mc_req = 1;
    cyc("rst_start", {4'b0, 7'b1110011});
    mc_req = 0;
    cyc("rst_w1", {4'b0, 7'b1110001});
    #2 rst_n = 0;
    #1;
    check("rst_async", 16'({sf, sd, se, fd, fe, mc_start, mc_err}), 16'd0);
    check("rst_cnt", 16'({stall_cnt, flush_cnt}), 16'd0);
    @(posedge clk);
    #1 rst_n = 1;
    scnt = 0; fcnt = 0;
    cyc("post_rst", 11'b0);
    cyc("post_rst2", 11'b0);
    if (q.size() != 0) check("queue_empty", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
